iob_sync_filt: RTL and testbench

//   Parametrised multi-stage synchroniser for asynchronous level inputs such as pins, status lines and foreign-domain flags.

---
 rtl/iob_sync_filt.sv | 92 +++++++++
 tb/tb_iob_sync_filt.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/iob_sync_filt.sv
// Multi-stage synchroniser with per-bit stability filter and registered rise/fall pulses.
// Latency: SYNC_STAGES + FILT_CNT edges from a held input change to signal_o (+1 on setup violation).
// No backpressure: free-running level path, every bit independent, outputs valid every cycle.
//
// Ports:
//   clk_i    - clock
//   arst_i   - asynchronous reset, active-high
//   signal_i - asynchronous input levels (DATA_W bits)
//   signal_o - synchronised, filtered levels
//   rise_o   - 1-cycle pulse coinciding with a signal_o bit going 0->1
//   fall_o   - 1-cycle pulse coinciding with a signal_o bit going 1->0
//   change_o - OR of all rise_o/fall_o bits
module iob_sync_filt #(
    parameter int                DATA_W      = 1,
    parameter int                SYNC_STAGES = 2,
    parameter int                FILT_CNT    = 1,
    parameter logic [DATA_W-1:0] RST_VAL     = '0
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] signal_i,
    output logic [DATA_W-1:0] signal_o,
    output logic [DATA_W-1:0] rise_o,
    output logic [DATA_W-1:0] fall_o,
    output logic              change_o
);

    localparam int               CNT_W    = $clog2(FILT_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_CNT - 1);

    // Plain flop chain: nothing may sit between stages so each stage gets a full
    // cycle to resolve metastability.
    logic [DATA_W-1:0] sync_q [SYNC_STAGES];
    logic [DATA_W-1:0] synced;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= RST_VAL;
            end
        end else begin
            sync_q[0] <= signal_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];

    logic [DATA_W-1:0] level_q;
    logic [DATA_W-1:0] rise_q;
    logic [DATA_W-1:0] fall_q;

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [CNT_W-1:0] cnt_q;

        // The counter tracks how many consecutive cycles the synced value has
        // disagreed with the accepted level; any agreement clears it, which is
        // what rejects glitches shorter than FILT_CNT cycles.
        always_ff @(posedge clk_i or posedge arst_i) begin
            if (arst_i) begin
                cnt_q      <= '0;
                level_q[b] <= RST_VAL[b];
                rise_q[b]  <= 1'b0;
                fall_q[b]  <= 1'b0;
            end else begin
                rise_q[b] <= 1'b0;
                fall_q[b] <= 1'b0;
                if (synced[b] == level_q[b]) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Pulses are registered on the same edge as the level so
                    // they line up with the new signal_o value.
                    level_q[b] <= synced[b];
                    rise_q[b]  <= synced[b];
                    fall_q[b]  <= ~synced[b];
                    cnt_q      <= '0;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign signal_o = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    // Built only from flops, so the OR cannot glitch on input activity.
    assign change_o = |(rise_q | fall_q);

endmodule

// File: tb/tb_iob_sync_filt.sv
// Self-checking bench for iob_sync_filt: directed scenarios with literal expectations
// plus a window-based behavioural model compared on every falling edge.
// Runs a fixed number of cycles and always reaches its summary line.
module tb_iob_sync_filt;

    localparam int          DW   = 4;
    localparam int          SYNC = 3;
    localparam int          FILT = 4;
    localparam logic [DW-1:0] RV = 4'h0;
    localparam int          HIST = SYNC + FILT;

    logic          clk_i    = 1'b0;
    logic          arst_i   = 1'b0;
    logic [DW-1:0] signal_i = '0;
    logic [DW-1:0] signal_o;
    logic [DW-1:0] rise_o;
    logic [DW-1:0] fall_o;
    logic          change_o;

    int errors = 0;
    int checks = 0;
    int pulse_cnt = 0;

    iob_sync_filt #(
        .DATA_W     (DW),
        .SYNC_STAGES(SYNC),
        .FILT_CNT   (FILT),
        .RST_VAL    (RV)
    ) dut (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .signal_i(signal_i),
        .signal_o(signal_o),
        .rise_o  (rise_o),
        .fall_o  (fall_o),
        .change_o(change_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: hist[0] is the input sampled at the current edge; the filter sees the
    // sample taken SYNC edges earlier. A bit's level flips when the last FILT seen
    // samples all disagree with it.
    logic [DW-1:0] hist [HIST];
    logic [DW-1:0] m_out  = RV;
    logic [DW-1:0] m_rise = '0;
    logic [DW-1:0] m_fall = '0;

    always @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < HIST; i++) hist[i] = RV;
            m_out  = RV;
            m_rise = '0;
            m_fall = '0;
        end else begin
            for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = signal_i;
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < DW; b++) begin
                logic flip;
                flip = 1'b1;
                for (int j = 0; j < FILT; j++) begin
                    if (hist[SYNC+j][b] == m_out[b]) flip = 1'b0;
                end
                if (flip) begin
                    m_out[b]  = ~m_out[b];
                    m_rise[b] = m_out[b];
                    m_fall[b] = ~m_out[b];
                end
            end
        end
    end

    logic          cmp_en    = 1'b0;
    logic [DW-1:0] prev_rise = '0;
    logic [DW-1:0] prev_fall = '0;

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("model signal_o", 32'(signal_o), 32'(m_out));
            chk("model rise_o",   32'(rise_o),   32'(m_rise));
            chk("model fall_o",   32'(fall_o),   32'(m_fall));
            chk("model change_o", 32'(change_o), 32'(|(m_rise | m_fall)));
            chk("rise 1-cycle",   32'(rise_o & prev_rise), 32'h0);
            chk("fall 1-cycle",   32'(fall_o & prev_fall), 32'h0);
        end
        prev_rise = rise_o;
        prev_fall = fall_o;
        if ((rise_o | fall_o) != '0 || change_o) pulse_cnt++;
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    initial begin
        for (int i = 0; i < HIST; i++) hist[i] = RV;
        #2 arst_i = 1'b1;
        #1;
        chk("reset signal_o", 32'(signal_o), 32'h0);
        chk("reset change_o", 32'(change_o), 32'h0);
        cmp_en = 1'b1;
        edges(3);
        arst_i = 1'b0;

        // 1. idle with zero input
        begin
            int p0;
            p0 = pulse_cnt;
            edges(20);
            chk("idle signal_o", 32'(signal_o), 32'h0);
            chk("idle pulses",   32'(pulse_cnt - p0), 32'h0);
        end

        // 2. single-bit step: level appears on exactly the 7th edge
        signal_i = 4'h1;
        edges(6);
        chk("step edge6 signal_o", 32'(signal_o), 32'h0);
        edges(1);
        chk("step edge7 signal_o", 32'(signal_o), 32'h1);
        chk("step rise_o",         32'(rise_o),   32'h1);
        chk("step change_o",       32'(change_o), 32'h1);
        edges(1);
        chk("step rise cleared",   32'(rise_o),   32'h0);
        chk("step change cleared", 32'(change_o), 32'h0);

        // 3. 3-cycle glitch rejected, 4-cycle pulse accepted
        begin
            int p0;
            p0 = pulse_cnt;
            signal_i = 4'h3;
            edges(3);
            signal_i = 4'h1;
            edges(12);
            chk("glitch signal_o", 32'(signal_o), 32'h1);
            chk("glitch pulses",   32'(pulse_cnt - p0), 32'h0);
        end
        signal_i = 4'h3;
        edges(4);
        signal_i = 4'h1;
        edges(3);
        chk("pulse4 rise_o",   32'(rise_o),   32'h2);
        chk("pulse4 signal_o", 32'(signal_o), 32'h3);
        edges(4);
        chk("pulse4 fall_o",   32'(fall_o),   32'h2);
        chk("pulse4 back",     32'(signal_o), 32'h1);

        // 4. all bits together
        signal_i = 4'h0;
        edges(12);
        chk("all pre", 32'(signal_o), 32'h0);
        signal_i = 4'hF;
        edges(7);
        chk("all rise_o",   32'(rise_o),   32'hF);
        chk("all signal_o", 32'(signal_o), 32'hF);
        signal_i = 4'h0;
        edges(7);
        chk("all fall_o",   32'(fall_o),   32'hF);
        chk("all cleared",  32'(signal_o), 32'h0);

        // 5. reset during a partial count
        signal_i = 4'h8;
        edges(7);
        chk("pre-reset signal_o", 32'(signal_o), 32'h8);
        signal_i = 4'h9;
        edges(5);
        arst_i = 1'b1;
        #1;
        chk("midreset signal_o", 32'(signal_o), 32'h0);
        chk("midreset rise_o",   32'(rise_o),   32'h0);
        chk("midreset fall_o",   32'(fall_o),   32'h0);
        chk("midreset change_o", 32'(change_o), 32'h0);
        edges(3);
        arst_i = 1'b0;
        edges(6);
        chk("post-reset edge6", 32'(signal_o), 32'h0);
        edges(1);
        chk("post-reset edge7", 32'(signal_o), 32'h9);
        chk("post-reset rise",  32'(rise_o),   32'h9);
        edges(1);
        chk("post-reset rise once", 32'(rise_o), 32'h0);

        // 6. random per-bit toggling against the model
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0) signal_i[$urandom_range(DW - 1)] ^= 1'b1;
            edges(1);
        end

        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
